// File: rtl/fetch_stage.sv
// fetch_stage: RISC-V instruction fetch with one outstanding imem request and the IF/ID register.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds a sticky misalign_o flag for unaligned redirects.
module fetch_stage #(
  parameter int unsigned       XLEN     = 32,
  parameter logic [XLEN-1:0]   RESET_PC = '0,
  parameter logic [31:0]       NOP_INST = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pc_sel_i,
  input  logic [XLEN-1:0] alu_target_i,
  input  logic            stall_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [31:0]     imem_rdata_i,
  output logic [31:0]     inst_o,
  output logic [XLEN-1:0] pc_o,
  output logic [XLEN-1:0] pc4_o,
  output logic            inst_valid_o
`ifdef FETCH_MISALIGN_CHECK_EN
  , output logic          misalign_o
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            drop_q, drop_d;
  logic [XLEN-1:0] pc_q, pc_d;

  logic            redirect;
  logic            rsp_live;
  logic            rsp_take;
  logic            rsp_hold;

  logic [31:0]     hold_inst_p0;
  logic [XLEN-1:0] hold_pc_p0;

  logic [31:0]     inst_p1;
  logic [XLEN-1:0] pc_p1;
  logic            vld_p1;

  function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] t);
    return t & ~XLEN'(3);
  endfunction

  function automatic logic [XLEN-1:0] pc_inc(input logic [XLEN-1:0] p);
    return p + XLEN'(4);
  endfunction

  // A stall masks the redirect for that cycle; a live response is one not marked for discard.
  assign redirect = pc_sel_i & ~stall_i;
  assign rsp_live = (state_q == S_WAIT) & imem_rvalid_i & ~drop_q;
  assign rsp_take = rsp_live & ~redirect & ~stall_i;
  assign rsp_hold = rsp_live & stall_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_REQ;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    drop_d  = drop_q;
    case (state_q)
      S_REQ: begin
        drop_d = imem_gnt_i & redirect;
        if (imem_gnt_i) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          drop_d  = 1'b0;
          state_d = rsp_hold ? S_HOLD : S_REQ;
        end else begin
          drop_d = drop_q | redirect;
        end
      end
      S_HOLD: begin
        drop_d = 1'b0;
        if (!stall_i) state_d = S_REQ;
      end
      default: begin
        state_d = S_REQ;
        drop_d  = 1'b0;
      end
    endcase
  end

  always_comb begin
    imem_req_o = rst & (state_q == S_REQ);
  end

  // Stage p0: program counter and the stall hold buffer
  always_comb begin
    pc_d = pc_q;
    if (redirect)      pc_d = align_target(alu_target_i);
    else if (rsp_live) pc_d = pc_inc(pc_q);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_q <= RESET_PC;
    else      pc_q <= pc_d;
  end

  always_ff @(posedge clk) begin
    if (rsp_hold) begin
      hold_inst_p0 <= imem_rdata_i;
      hold_pc_p0   <= pc_q;
    end
  end

  // Stage p1: IF/ID register; pc_p1 keeps its last value whenever the slot empties
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst_p1 <= NOP_INST;
      pc_p1   <= '0;
      vld_p1  <= 1'b0;
    end else if (!stall_i) begin
      if (redirect) begin
        inst_p1 <= NOP_INST;
        vld_p1  <= 1'b0;
      end else if (rsp_take) begin
        inst_p1 <= imem_rdata_i;
        pc_p1   <= pc_q;
        vld_p1  <= 1'b1;
      end else if (state_q == S_HOLD) begin
        inst_p1 <= hold_inst_p0;
        pc_p1   <= hold_pc_p0;
        vld_p1  <= 1'b1;
      end else begin
        inst_p1 <= NOP_INST;
        vld_p1  <= 1'b0;
      end
    end
  end

  assign imem_addr_o  = pc_q;
  assign inst_o       = inst_p1;
  assign pc_o         = pc_p1;
  assign pc4_o        = pc_inc(pc_p1);
  assign inst_valid_o = vld_p1;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  misalign_q <= 1'b0;
    else if (redirect && |alu_target_i[1:0])   misalign_q <= 1'b1;
  end

  assign misalign_o = misalign_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench for fetch_stage with a small req/gnt/rvalid memory responder.
// Expected instructions and grant addresses are queued by the stimulus and popped by monitors.
`timescale 1ns/1ps
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        pc_sel_i = 1'b0;
  logic [31:0] alu_target_i = 32'h0;
  logic        stall_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic [31:0] pc4_o;
  logic        inst_valid_o;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        misalign_o;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  exp_t        inst_q[$];
  logic [31:0] addr_q[$];

  int          gnt_budget = 0;
  int          rsp_lat = 1;
  int          lat_cnt = 0;
  bit          jal_en = 1'b0;
  logic [31:0] gnt_addr = 32'h0;
  logic [31:0] pend_addr = 32'h0;

  fetch_stage dut (
    .clk          (clk),
    .rst          (rst),
    .pc_sel_i     (pc_sel_i),
    .alu_target_i (alu_target_i),
    .stall_i      (stall_i),
    .imem_req_o   (imem_req_o),
    .imem_addr_o  (imem_addr_o),
    .imem_gnt_i   (imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i),
    .imem_rdata_i (imem_rdata_i),
    .inst_o       (inst_o),
    .pc_o         (pc_o),
    .pc4_o        (pc4_o),
    .inst_valid_o (inst_valid_o)
`ifdef FETCH_MISALIGN_CHECK_EN
    , .misalign_o (misalign_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rsp_word(input logic [31:0] a);
    if (jal_en && a == 32'h0000_0008) return 32'h0000_F16F;
    return a ^ 32'hA5A5_0000;
  endfunction

  // Memory responder: grants while budget remains, answers rsp_lat cycles after acceptance.
  initial begin
    imem_gnt_i    = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hDEAD_BEEF;
    forever begin
      @(posedge clk); #1;
      if (imem_gnt_i) begin
        pend_addr = gnt_addr;
        lat_cnt   = rsp_lat;
      end
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = rsp_word(pend_addr);
        end
      end
      imem_gnt_i = 1'b0;
      if (imem_req_o && gnt_budget > 0 && lat_cnt == 0) begin
        imem_gnt_i = 1'b1;
        gnt_addr   = imem_addr_o;
        gnt_budget--;
      end
    end
  end

  // Monitors: a visible instruction is consumed when not stalled; a request when granted.
  exp_t mon_e;
  logic [31:0] mon_a;
  always @(negedge clk) begin
    if (rst && inst_valid_o && !stall_i) begin
      n_cmp++;
      if (inst_q.size() == 0) begin
        n_bad++;
        $display("FAIL inst_unexpected: got inst=%h pc=%h, required no instruction", inst_o, pc_o);
      end else begin
        mon_e = inst_q.pop_front();
        if (inst_o !== mon_e.inst || pc_o !== mon_e.pc) begin
          n_bad++;
          $display("FAIL inst_seq: got inst=%h pc=%h, required inst=%h pc=%h",
                   inst_o, pc_o, mon_e.inst, mon_e.pc);
        end
      end
    end
    if (rst && imem_req_o && imem_gnt_i) begin
      n_cmp++;
      if (addr_q.size() == 0) begin
        n_bad++;
        $display("FAIL req_unexpected: got addr=%h, required no request", imem_addr_o);
      end else begin
        mon_a = addr_q.pop_front();
        if (imem_addr_o !== mon_a) begin
          n_bad++;
          $display("FAIL req_addr: got %h, required %h", imem_addr_o, mon_a);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic push_inst(input logic [31:0] inst, input logic [31:0] pc);
    exp_t e;
    e.inst = inst;
    e.pc   = pc;
    inst_q.push_back(e);
  endtask

  task automatic timeout_fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL timeout_%s: got no event within budget, required event", name);
  endtask

  task automatic wait_valid(input string name);
    int t = 0;
    while (!inst_valid_o && t < 40) begin step(); t++; end
    if (!inst_valid_o) timeout_fail(name);
  endtask

  task automatic wait_accept(input string name);
    int t = 0;
    while (!(imem_req_o && imem_gnt_i) && t < 40) begin step(); t++; end
    if (!(imem_req_o && imem_gnt_i)) timeout_fail(name);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((inst_q.size() != 0 || addr_q.size() != 0) && t < 80) begin step(); t++; end
    if (inst_q.size() != 0 || addr_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_%s: got %0d inst and %0d addr pending, required 0",
               name, inst_q.size(), addr_q.size());
      inst_q.delete();
      addr_q.delete();
    end
  endtask

  initial begin
    int t;
    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_inst", inst_o, NOP);
    check("rst_pc", pc_o, 32'h0);
    check("rst_valid", 32'(inst_valid_o), 32'd0);
    check("rst_req", 32'(imem_req_o), 32'd0);
    check("rst_addr", imem_addr_o, 32'h0);

    // Zero-wait fetch of 0x0, 0x4, 0x8
    for (int i = 0; i < 3; i++) begin
      addr_q.push_back(32'(i * 4));
      push_inst(32'(i * 4) ^ 32'hA5A5_0000, 32'(i * 4));
    end
    gnt_budget = 3;
    rst = 1'b1;
    wait_valid("first_valid");
    step(); check("valid_gap_1", 32'(inst_valid_o), 32'd0);
    step(); check("valid_2nd", 32'(inst_valid_o), 32'd1);
    step(); check("valid_gap_2", 32'(inst_valid_o), 32'd0);
    step(); check("valid_3rd", 32'(inst_valid_o), 32'd1);
    drain("zero_wait");

    // Stall for 3 cycles starting at the rvalid of 0xC
    addr_q.push_back(32'h0000_000C);
    addr_q.push_back(32'h0000_0010);
    push_inst(32'hA5A5_000C, 32'h0000_000C);
    push_inst(32'hA5A5_0010, 32'h0000_0010);
    gnt_budget = 2;
    t = 0;
    while (!imem_rvalid_i && t < 40) begin step(); t++; end
    if (!imem_rvalid_i) timeout_fail("stall_rvalid");
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_req", 32'(imem_req_o), 32'd0);
      check("stall_inst", inst_o, NOP);
      check("stall_pc", pc_o, 32'h0000_0008);
      @(posedge clk); #2;
    end
    stall_i = 1'b0;
    step();
    check("unstall_inst", inst_o, 32'hA5A5_000C);
    check("unstall_pc", pc_o, 32'h0000_000C);
    drain("stall");

    // Redirect to 0x40 while waiting; stale response for 0x14 lands two cycles later
    addr_q.push_back(32'h0000_0014);
    addr_q.push_back(32'h0000_0040);
    push_inst(32'hA5A5_0040, 32'h0000_0040);
    rsp_lat = 3;
    gnt_budget = 2;
    wait_accept("wait_redir_gnt");
    step();
    pc_sel_i = 1'b1;
    alu_target_i = 32'h0000_0040;
    step();
    pc_sel_i = 1'b0;
    rsp_lat = 1;
    check("wait_redir_addr", imem_addr_o, 32'h0000_0040);
    check("wait_redir_req", 32'(imem_req_o), 32'd0);
    drain("wait_redirect");

    // Reset while waiting for 0x44, late rvalid arrives after release
    addr_q.push_back(32'h0000_0044);
    rsp_lat = 3;
    gnt_budget = 1;
    wait_accept("rst_wait_gnt");
    step();
    rst = 1'b0;
    #1;
    check("midrst_inst", inst_o, NOP);
    check("midrst_pc", pc_o, 32'h0);
    check("midrst_valid", 32'(inst_valid_o), 32'd0);
    check("midrst_req", 32'(imem_req_o), 32'd0);
    check("midrst_addr", imem_addr_o, 32'h0);
    step();
    rsp_lat = 1;
    jal_en = 1'b1;
    gnt_budget = 5;
    addr_q.push_back(32'h0000_0000);
    addr_q.push_back(32'h0000_0004);
    addr_q.push_back(32'h0000_0008);
    addr_q.push_back(32'h0000_000C);
    addr_q.push_back(32'h0000_0100);
    push_inst(32'hA5A5_0000, 32'h0000_0000);
    push_inst(32'hA5A5_0004, 32'h0000_0004);
    push_inst(32'h0000_F16F, 32'h0000_0008);
    push_inst(32'hA5A5_0100, 32'h0000_0100);
    rst = 1'b1;

    // JAL at 0x8 redirects to 0x100 while 0xC is granted in the same cycle
    t = 0;
    while (!(inst_valid_o && inst_o == 32'h0000_F16F) && t < 40) begin step(); t++; end
    if (!(inst_valid_o && inst_o == 32'h0000_F16F)) timeout_fail("jal_visible");
    pc_sel_i = 1'b1;
    alu_target_i = 32'h0000_0100;
    step();
    pc_sel_i = 1'b0;
    check("jal_flush_inst", inst_o, NOP);
    check("jal_flush_valid", 32'(inst_valid_o), 32'd0);
    check("jal_addr", imem_addr_o, 32'h0000_0100);
    drain("jal");

    // Stall beats a simultaneous redirect; then wrap-around at 0xFFFF_FFFC
    stall_i = 1'b1;
    pc_sel_i = 1'b1;
    alu_target_i = 32'h0000_0200;
    step();
    check("stall_wins_addr", imem_addr_o, 32'h0000_0104);
    stall_i = 1'b0;
    alu_target_i = 32'hFFFF_FFFC;
    step();
    pc_sel_i = 1'b0;
    check("wrap_redir_addr", imem_addr_o, 32'hFFFF_FFFC);
    addr_q.push_back(32'hFFFF_FFFC);
    addr_q.push_back(32'h0000_0000);
    push_inst(32'h5A5A_FFFC, 32'hFFFF_FFFC);
    push_inst(32'hA5A5_0000, 32'h0000_0000);
    gnt_budget = 2;
    t = 0;
    while (!(inst_valid_o && pc_o == 32'hFFFF_FFFC) && t < 40) begin step(); t++; end
    if (!(inst_valid_o && pc_o == 32'hFFFF_FFFC)) timeout_fail("wrap_visible");
    check("wrap_pc4", pc4_o, 32'h0000_0000);
    drain("wrap");

`ifdef FETCH_MISALIGN_CHECK_EN
    check("misalign_clear", 32'(misalign_o), 32'd0);
    pc_sel_i = 1'b1;
    alu_target_i = 32'h0000_0102;
    step();
    pc_sel_i = 1'b0;
    check("misalign_addr", imem_addr_o, 32'h0000_0100);
    check("misalign_set", 32'(misalign_o), 32'd1);
    repeat (3) step();
    check("misalign_sticky", 32'(misalign_o), 32'd1);
    rst = 1'b0;
    #1;
    check("misalign_rst", 32'(misalign_o), 32'd0);
    step();
    rst = 1'b1;
`endif

    repeat (4) step();
    check("final_inst_q", 32'(inst_q.size()), 32'd0);
    check("final_addr_q", 32'(addr_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage of the RISC-V core, directly upstream of control_logic.
- Holds the PC and issues one instruction-memory request at a time through a req/gnt/rvalid handshake.
- Writes the returned word into the IF/ID register; inst_o drives control_logic inst_i.
- Takes pc_sel back from control_logic to redirect the PC and flush the fetched instruction.

Parameters:
XLEN, 32, datapath and address width
RESET_PC, 32'h0000_0000, first fetch address after reset
NOP_INST, 32'h0000_0013, word driven on inst_o when the IF/ID slot is empty (addi x0,x0,0)

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-low
pc_sel_i  input  1  from control_logic pc_sel_o; 1 = redirect PC to alu_target_i
alu_target_i  input  XLEN  branch/jump target from the ALU
stall_i  input  1  downstream hold; IF/ID must not change
imem_req_o  output  1  fetch request
imem_addr_o  output  XLEN  fetch address (= pc_q)
imem_gnt_i  input  1  request accepted this cycle
imem_rvalid_i  input  1  read data valid
imem_rdata_i  input  32  read data
inst_o  output  32  IF/ID instruction, to control_logic inst_i
pc_o  output  XLEN  PC of inst_o
pc4_o  output  XLEN  pc_o + 4 (combinational, wraps mod 2^XLEN)
inst_valid_o  output  1  inst_o holds a real instruction

Behaviour:
- Reset (rst=0, async):
  - pc_q=RESET_PC, state=S_REQ, drop=0, hold buffer empty.
  - inst_o=NOP_INST, pc_o=0, inst_valid_o=0.
  - imem_req_o forced 0 while rst=0.
- Single outstanding request. imem_req_o=1 only in S_REQ. imem_addr_o=pc_q always.
- S_REQ:
  - gnt=1 -> S_WAIT.
  - gnt=0 -> stay; address held stable.
- S_WAIT:
  - imem_rvalid_i=1 and drop=1 -> discard the data, clear drop, go to S_REQ.
  - rvalid=1, drop=0, stall_i=0 -> IF/ID <= {rdata, pc_q, valid=1}; pc_q += 4; go to S_REQ.
  - rvalid=1, drop=0, stall_i=1 -> data and pc into the hold buffer; pc_q += 4; go to S_HOLD.
  - rvalid ignored in all states other than S_WAIT.
- S_HOLD: when stall_i=0, IF/ID <= buffer; go to S_REQ.
- Empty slot: stall_i=0 and no new data -> inst_valid_o=0, inst_o=NOP_INST; pc_o keeps its last value.
- Stall: stall_i=1 -> IF/ID holds every field unchanged.
- Redirect, sampled only when stall_i=0; when stall_i=1 and pc_sel_i=1, stall wins and the redirect is ignored that cycle:
  - pc_q <= {alu_target_i[XLEN-1:2], 2'b00}.
  - IF/ID flushed next cycle: inst_o=NOP_INST, inst_valid_o=0.
  - S_REQ with gnt=1 the same cycle: drop=1, go to S_WAIT.
  - S_REQ without gnt: stay in S_REQ at the new address.
  - S_WAIT: drop=1 (or already set); a response arriving the same cycle is discarded.
  - S_HOLD: buffer cleared, go to S_REQ.
  - Redirect has priority over loading a response into IF/ID.
- Latency:
  - Zero-wait memory (gnt with req, rvalid one cycle later): 2 cycles per instruction.
  - Redirect to first request at the target: 1 cycle.
- pc_q wraps 0xFFFF_FFFC -> 0x0000_0000. No trap.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - Adds output misalign_o (1 bit, reset 0).
  - Set sticky when an accepted redirect has alu_target_i[1:0] != 0.
  - Cleared only by reset.
  - Target still aligned as above.
- Undefined: port absent; alignment silently forced.

Test Plan:
- Reset release, zero-wait memory returning addr^0xA5A5_0000:
  - imem_addr_o sequence 0x0, 0x4, 0x8.
  - inst_o = 0xA5A5_0000, 0xA5A5_0004, 0xA5A5_0008 with pc_o matching.
  - inst_valid_o=1 every 2nd cycle.
- stall_i=1 for 3 cycles when rvalid arrives:
  - inst_o/pc_o frozen; imem_req_o=0.
  - Cycle after stall_i falls: the buffered word appears on inst_o, then fetch resumes at pc+4.
- inst_o=0x0000_F16F (JAL) at pc 0x8, pc_sel_i=1, alu_target_i=0x100:
  - Next cycle inst_o=NOP_INST, inst_valid_o=0, imem_addr_o=0x100.
  - Next valid pc_o=0x100.
- Redirect to 0x40 while in S_WAIT, rvalid two cycles later:
  - Stale word never reaches inst_o.
  - Next request address 0x40.
- rst asserted mid-S_WAIT, then late rvalid after release:
  - Outputs at reset values immediately; late rvalid ignored.
  - Fetch restarts at RESET_PC.
- pc_q=0xFFFF_FFFC fetch: pc4_o=0x0 and next imem_addr_o=0x0.
- With FETCH_MISALIGN_CHECK_EN, redirect to 0x102: imem_addr_o=0x100, misalign_o=1 until reset.
